bcd_conv_arbiter: RTL and testbench

Round-robin controller that shares one binary_to_BCD_converter instance between NUM_REQ requesters.
- Accepts one request at a time and launches the converter with a single-cycle start.
- Waits for the converter's done, then returns the BCD result, tagged with the requester id, on a shared response channel.
- A watchdog converts a missing done into an error response, so the arbiter never hangs.

---
 rtl/bcd_conv_pkg.sv | 12 +
 rtl/bcd_rr_picker.sv | 32 +++
 rtl/bcd_conv_arbiter.sv | 140 ++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 525 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_conv_pkg.sv
// Shared state encoding and default widths for the BCD converter arbiter.
package bcd_conv_pkg;
  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_e;

  localparam int BIN_W = 32;
  localparam int BCD_W = 40;
endpackage

// File: rtl/bcd_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module bcd_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic               grant_valid_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o
);
  logic [ID_W:0] idx;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_o       = '0;
    grant_id_o    = '0;
    idx           = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // one spare bit keeps rr_ptr + i exact before the modulo fold
      idx = {1'b0, rr_ptr_i} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_valid_o && req_i[idx[ID_W-1:0]]) begin
        grant_valid_o             = 1'b1;
        grant_o[idx[ID_W-1:0]]    = 1'b1;
        grant_id_o                = idx[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sharing of one binary-to-BCD converter with a watchdog on done.
module bcd_conv_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BIN_W     = bcd_conv_pkg::BIN_W,
  parameter int BCD_W     = bcd_conv_pkg::BCD_W,
  parameter int TIMEOUT   = 64,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*BIN_W-1:0] req_binary_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [ID_W-1:0]          resp_id_o,
  output logic [BCD_W-1:0]         resp_bcd_o,
  output logic                     resp_err_o,
  output logic                     busy_o,
  output logic                     conv_start_o,
  output logic [BIN_W-1:0]         conv_binary_o,
  input  logic                     conv_ready_i,
  input  logic                     conv_done_i,
  input  logic [BCD_W-1:0]         conv_bcd_i
);
  import bcd_conv_pkg::*;

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [BIN_W-1:0]   operand_q, operand_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               err_q, err_d;

  logic               grant_valid;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [BIN_W-1:0]   operand_sel;
  logic               accept;

  bcd_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i         (req_valid_i),
    .rr_ptr_i      (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant),
    .grant_id_o    (grant_id)
  );

  always_comb begin
    operand_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        operand_sel = req_binary_i[k*BIN_W +: BIN_W];
      end
    end
  end

  // no handshake may complete in a reset cycle, it would be lost
  assign accept = (state_q == IDLE) && conv_ready_i
                  && grant_valid && !reset_i;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    timer_d   = timer_q;
    operand_d = operand_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          id_d      = grant_id;
          operand_d = operand_sel;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (conv_done_i) begin
          bcd_d   = conv_bcd_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          bcd_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      timer_q   <= '0;
      operand_q <= '0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      timer_q   <= timer_d;
      operand_q <= operand_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
    end
  end

  assign req_ready_o   = accept ? grant : '0;
  assign busy_o        = (state_q != IDLE);
  assign conv_start_o  = (state_q == LAUNCH);
  assign conv_binary_o = (state_q == LAUNCH || state_q == WAIT)
                         ? operand_q : '0;
  assign resp_valid_o  = (state_q == RESP);
  assign resp_id_o     = id_q;
  assign resp_bcd_o    = bcd_q;
  assign resp_err_o    = err_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a behavioural converter model.
module tb_bcd_conv_arbiter;
  localparam int N  = 4;
  localparam int BW = 32;
  localparam int CW = 40;
  localparam int TO = 16;
  localparam int IW = 2;
  localparam logic [CW-1:0] JUNK = 40'hBADBADBAD0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [CW-1:0] bcd;
    logic          err;
  } resp_t;

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*BW-1:0] req_bin = '0;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [IW-1:0]   resp_id;
  logic [CW-1:0]   resp_bcd;
  logic            resp_err;
  logic            busy;
  logic            conv_start;
  logic [BW-1:0]   conv_binary;
  logic            conv_ready;
  logic            conv_done = 1'b0;
  logic [CW-1:0]   conv_bcd = JUNK;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(
    .NUM_REQ (N),
    .BIN_W   (BW),
    .BCD_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .req_valid_i   (req_valid),
    .req_binary_i  (req_bin),
    .req_ready_o   (req_ready),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_id_o     (resp_id),
    .resp_bcd_o    (resp_bcd),
    .resp_err_o    (resp_err),
    .busy_o        (busy),
    .conv_start_o  (conv_start),
    .conv_binary_o (conv_binary),
    .conv_ready_i  (conv_ready),
    .conv_done_i   (conv_done),
    .conv_bcd_i    (conv_bcd)
  );

  function automatic logic [CW-1:0] to_bcd(input logic [BW-1:0] v);
    logic [CW-1:0] r = '0;
    logic [BW-1:0] t = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // converter model: conv_lat cycles after start; hang mode never pulses done
  logic          conv_busy = 1'b0;
  int            conv_cnt = 0;
  logic [BW-1:0] conv_op = '0;
  int            conv_lat = 3;
  bit            conv_hang = 1'b0;
  int            cyc = 0;

  assign conv_ready = !conv_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    conv_done <= 1'b0;
    conv_bcd  <= JUNK;
    if (conv_start) begin
      conv_busy <= 1'b1;
      conv_op   <= conv_binary;
      conv_cnt  <= conv_lat;
    end else if (conv_busy) begin
      if (conv_cnt <= 1) begin
        conv_busy <= 1'b0;
        if (!conv_hang) begin
          conv_done <= 1'b1;
          conv_bcd  <= to_bcd(conv_op);
        end
      end else begin
        conv_cnt <= conv_cnt - 1;
      end
    end
  end

  int            grant_id_q[$];
  int            grant_cyc[$];
  int            start_cyc[$];
  logic [BW-1:0] start_op[$];
  int            done_cyc[$];
  int            rise_cyc[$];
  int            resp_cyc[$];
  resp_t         resp_log[$];
  int            bad_ready = 0;
  logic          prev_valid = 1'b0;
  resp_t         mon_r;

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (req_ready[k] && req_valid[k]) begin
        grant_id_q.push_back(k);
        grant_cyc.push_back(cyc);
      end
    end
    if (conv_start) begin
      start_op.push_back(conv_binary);
      start_cyc.push_back(cyc);
    end
    if (conv_done) done_cyc.push_back(cyc);
    if (resp_valid && !prev_valid) rise_cyc.push_back(cyc);
    if (resp_valid && resp_ready) begin
      mon_r.id  = resp_id;
      mon_r.bcd = resp_bcd;
      mon_r.err = resp_err;
      resp_log.push_back(mon_r);
      resp_cyc.push_back(cyc);
    end
    if (busy && |req_ready) bad_ready++;
    prev_valid = resp_valid;
  end

  int           tests = 0;
  int           fails = 0;
  logic [N-1:0] hold = '0;
  int           gseen = 0;
  resp_t        exp_q[$];

  task automatic set_req(input int k, input logic [BW-1:0] op);
    req_bin[k*BW +: BW] = op;
    req_valid[k] = 1'b1;
  endtask

  // advance one cycle; requesters drop valid after their accept edge
  task automatic tick();
    @(posedge clk);
    #1;
    while (gseen < grant_id_q.size()) begin
      if (!hold[grant_id_q[gseen]]) req_valid[grant_id_q[gseen]] = 1'b0;
      gseen++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    req_valid = '0;
    hold = '0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    gseen = grant_id_q.size();
    for (int c = 0; c < 20 && !conv_ready; c++) tick();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({req_ready, resp_valid, resp_id, resp_bcd, resp_err,
         busy, conv_start, conv_binary} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, want 0",
               {req_ready, resp_valid, resp_id, resp_bcd, resp_err,
                busy, conv_start, conv_binary});
    end
    reset_i = 1'b0;
    tick();
    tests++;
    if ({busy, resp_valid, conv_start} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: busy/valid/start=%b, want 000",
               {busy, resp_valid, conv_start});
    end
  endtask

  task automatic test_single();
    int rb, sb, gb, db;
    resp_t e, a;
    do_reset();
    rb = resp_log.size();
    sb = start_op.size();
    gb = grant_cyc.size();
    db = done_cyc.size();
    exp_q.push_back(resp_t'{id: 2'd1, bcd: 40'h0000012345, err: 1'b0});
    set_req(1, 32'd12345);
    for (int c = 0; c < 60 && resp_log.size() < rb + 1; c++) tick();
    tests++;
    if (start_op.size() - sb != 1) begin
      fails++;
      $display("FAIL single_starts: got %0d, want 1", start_op.size() - sb);
    end
    tests++;
    if (start_op.size() > sb && start_op[sb] !== 32'd12345) begin
      fails++;
      $display("FAIL single_operand: got %0d, want 12345", start_op[sb]);
    end
    tests++;
    if (start_cyc.size() > sb && grant_cyc.size() > gb &&
        start_cyc[sb] - grant_cyc[gb] != 1) begin
      fails++;
      $display("FAIL single_start_lat: got %0d, want 1",
               start_cyc[sb] - grant_cyc[gb]);
    end
    tests++;
    if (done_cyc.size() > db && rise_cyc.size() > 0 &&
        rise_cyc[rise_cyc.size()-1] - done_cyc[db] != 1) begin
      fails++;
      $display("FAIL single_resp_lat: got %0d, want 1",
               rise_cyc[rise_cyc.size()-1] - done_cyc[db]);
    end
    tests++;
    if (rise_cyc.size() > 0 && resp_cyc.size() > 0 &&
        rise_cyc[rise_cyc.size()-1] != resp_cyc[resp_cyc.size()-1]) begin
      fails++;
      $display("FAIL single_resp_one_cycle: rise %0d accept %0d, want equal",
               rise_cyc[rise_cyc.size()-1], resp_cyc[resp_cyc.size()-1]);
    end
    while (exp_q.size() > 0 && rb < resp_log.size()) begin
      e = exp_q.pop_front();
      a = resp_log[rb++];
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL single_resp: got id=%0d bcd=%h err=%b, want id=%0d bcd=%h err=%b",
                 a.id, a.bcd, a.err, e.id, e.bcd, e.err);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_missing: %0d responses not seen, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_simultaneous();
    int rb, gb;
    resp_t e, a;
    do_reset();
    rb = resp_log.size();
    gb = grant_id_q.size();
    exp_q.push_back(resp_t'{id: 2'd0, bcd: 40'h0, err: 1'b0});
    exp_q.push_back(resp_t'{id: 2'd1, bcd: 40'h9, err: 1'b0});
    exp_q.push_back(resp_t'{id: 2'd2, bcd: 40'h99, err: 1'b0});
    exp_q.push_back(resp_t'{id: 2'd3, bcd: 40'h4294967295, err: 1'b0});
    set_req(0, 32'd0);
    set_req(1, 32'd9);
    set_req(2, 32'd99);
    set_req(3, 32'hFFFF_FFFF);
    for (int c = 0; c < 200 && resp_log.size() < rb + 4; c++) tick();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (grant_id_q.size() <= gb + i || grant_id_q[gb+i] != i) begin
        fails++;
        $display("FAIL simul_grant_order[%0d]: got %0d, want %0d", i,
                 (grant_id_q.size() > gb + i) ? grant_id_q[gb+i] : -1, i);
      end
    end
    while (exp_q.size() > 0 && rb < resp_log.size()) begin
      e = exp_q.pop_front();
      a = resp_log[rb++];
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL simul_resp: got id=%0d bcd=%h err=%b, want id=%0d bcd=%h err=%b",
                 a.id, a.bcd, a.err, e.id, e.bcd, e.err);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL simul_missing: %0d responses not seen, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_fairness();
    int rb, gb, want;
    resp_t e, a;
    do_reset();
    rb = resp_log.size();
    gb = grant_id_q.size();
    hold = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(resp_t'{id: 2'd0, bcd: 40'h5, err: 1'b0});
      exp_q.push_back(resp_t'{id: 2'd2, bcd: 40'h7, err: 1'b0});
    end
    set_req(0, 32'd5);
    set_req(2, 32'd7);
    for (int c = 0; c < 200 && resp_log.size() < rb + 4; c++) tick();
    req_valid = '0;
    hold = '0;
    repeat (5) tick();
    tests++;
    if (grant_id_q.size() - gb != 4) begin
      fails++;
      $display("FAIL fair_grant_count: got %0d, want 4", grant_id_q.size() - gb);
    end
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 0 : 2;
      tests++;
      if (grant_id_q.size() <= gb + i || grant_id_q[gb+i] != want) begin
        fails++;
        $display("FAIL fair_grant[%0d]: got %0d, want %0d", i,
                 (grant_id_q.size() > gb + i) ? grant_id_q[gb+i] : -1, want);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (grant_cyc.size() <= gb + i + 1 || resp_cyc.size() <= rb + i ||
          grant_cyc[gb+i+1] - resp_cyc[rb+i] != 1) begin
        fails++;
        $display("FAIL fair_idle_gap[%0d]: gap wrong or missing, want 1", i);
      end
    end
    while (exp_q.size() > 0 && rb < resp_log.size()) begin
      e = exp_q.pop_front();
      a = resp_log[rb++];
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL fair_resp: got id=%0d bcd=%h err=%b, want id=%0d bcd=%h err=%b",
                 a.id, a.bcd, a.err, e.id, e.bcd, e.err);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int rb, sb, gb;
    resp_t e, a, cur, held;
    do_reset();
    resp_ready = 1'b0;
    rb = resp_log.size();
    gb = grant_id_q.size();
    held = resp_t'{id: 2'd3, bcd: 40'h777, err: 1'b0};
    exp_q.push_back(held);
    set_req(3, 32'd777);
    for (int c = 0; c < 60 && !resp_valid; c++) tick();
    sb = start_op.size();
    set_req(1, 32'd55);
    exp_q.push_back(resp_t'{id: 2'd1, bcd: 40'h55, err: 1'b0});
    for (int c = 0; c < 10; c++) begin
      tick();
      cur = resp_t'{id: resp_id, bcd: resp_bcd, err: resp_err};
      tests++;
      if (resp_valid !== 1'b1 || cur !== held || req_ready !== '0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b resp=%h ready=%b, want 1 %h 0",
                 c, resp_valid, cur, req_ready, held);
      end
    end
    tests++;
    if (start_op.size() != sb) begin
      fails++;
      $display("FAIL bp_no_start: got %0d starts, want 0", start_op.size() - sb);
    end
    tests++;
    if (bad_ready != 0) begin
      fails++;
      $display("FAIL bp_ready_outside_idle: got %0d, want 0", bad_ready);
    end
    resp_ready = 1'b1;
    for (int c = 0; c < 100 && resp_log.size() < rb + 2; c++) tick();
    tests++;
    if (grant_id_q.size() <= gb + 1 || grant_id_q[gb+1] != 1) begin
      fails++;
      $display("FAIL bp_next_grant: wrong or missing, want 1");
    end
    while (exp_q.size() > 0 && rb < resp_log.size()) begin
      e = exp_q.pop_front();
      a = resp_log[rb++];
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL bp_resp: got id=%0d bcd=%h err=%b, want id=%0d bcd=%h err=%b",
                 a.id, a.bcd, a.err, e.id, e.bcd, e.err);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_missing: %0d responses not seen, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_watchdog();
    int rb, sb;
    resp_t e, a;
    do_reset();
    conv_hang = 1'b1;
    rb = resp_log.size();
    sb = start_cyc.size();
    exp_q.push_back(resp_t'{id: 2'd2, bcd: 40'h0, err: 1'b1});
    set_req(2, 32'd4321);
    for (int c = 0; c < 100 && resp_log.size() < rb + 1; c++) tick();
    tests++;
    if (start_cyc.size() <= sb || rise_cyc.size() == 0 ||
        rise_cyc[rise_cyc.size()-1] - start_cyc[sb] != TO + 1) begin
      fails++;
      $display("FAIL wd_latency: got %0d, want %0d",
               (start_cyc.size() > sb && rise_cyc.size() > 0) ?
               rise_cyc[rise_cyc.size()-1] - start_cyc[sb] : -1, TO + 1);
    end
    conv_hang = 1'b0;
    for (int c = 0; c < 20 && !conv_ready; c++) tick();
    exp_q.push_back(resp_t'{id: 2'd0, bcd: 40'h31, err: 1'b0});
    set_req(0, 32'd31);
    for (int c = 0; c < 100 && resp_log.size() < rb + 2; c++) tick();
    while (exp_q.size() > 0 && rb < resp_log.size()) begin
      e = exp_q.pop_front();
      a = resp_log[rb++];
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL wd_resp: got id=%0d bcd=%h err=%b, want id=%0d bcd=%h err=%b",
                 a.id, a.bcd, a.err, e.id, e.bcd, e.err);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL wd_missing: %0d responses not seen, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_wait();
    int rb, sb, gb;
    resp_t e, a;
    do_reset();
    conv_lat = 8;
    rb = resp_log.size();
    exp_q.push_back(resp_t'{id: 2'd1, bcd: 40'h11, err: 1'b0});
    set_req(1, 32'd11);
    for (int c = 0; c < 100 && resp_log.size() < rb + 1; c++) tick();
    sb = start_op.size();
    set_req(2, 32'd22);
    for (int c = 0; c < 40 && start_op.size() <= sb; c++) tick();
    repeat (2) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tests++;
    if ({req_ready, resp_valid, resp_id, resp_bcd, resp_err,
         busy, conv_start, conv_binary} !== '0) begin
      fails++;
      $display("FAIL rst_wait_outputs: got %h, want 0",
               {req_ready, resp_valid, resp_id, resp_bcd, resp_err,
                busy, conv_start, conv_binary});
    end
    repeat (12) tick();
    tests++;
    if (resp_log.size() != rb + 1) begin
      fails++;
      $display("FAIL rst_wait_no_resp: got %0d responses, want 1", resp_log.size() - rb);
    end
    gb = grant_id_q.size();
    exp_q.push_back(resp_t'{id: 2'd0, bcd: 40'h40, err: 1'b0});
    exp_q.push_back(resp_t'{id: 2'd3, bcd: 40'h33, err: 1'b0});
    set_req(0, 32'd40);
    set_req(3, 32'd33);
    for (int c = 0; c < 200 && resp_log.size() < rb + 3; c++) tick();
    tests++;
    if (grant_id_q.size() <= gb || grant_id_q[gb] != 0) begin
      fails++;
      $display("FAIL rst_wait_first_grant: got %0d, want 0",
               (grant_id_q.size() > gb) ? grant_id_q[gb] : -1);
    end
    while (exp_q.size() > 0 && rb < resp_log.size()) begin
      e = exp_q.pop_front();
      a = resp_log[rb++];
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL rst_wait_resp: got id=%0d bcd=%h err=%b, want id=%0d bcd=%h err=%b",
                 a.id, a.bcd, a.err, e.id, e.bcd, e.err);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rst_wait_missing: %0d responses not seen, want 0", exp_q.size());
    end
    exp_q.delete();
    conv_lat = 3;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_watchdog();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end
endmodule
